// File: rtl/dht22_sensor_emu_pkg.sv
// Shared types and default timing for the DHT22 sensor emulator.
// Holds the state encoding, the default phase lengths in microseconds and the checksum helper.
package dht22_sensor_emu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_WAIT,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END,
    ST_ARM
  } state_t;

  localparam int DEF_CYC_PER_US     = 100;
  localparam int DEF_T_START_MIN_US = 500;
  localparam int DEF_T_WAIT_US      = 30;
  localparam int DEF_T_ACK_US       = 80;
  localparam int DEF_T_BIT_LOW_US   = 50;
  localparam int DEF_T_ZERO_US      = 27;
  localparam int DEF_T_ONE_US       = 70;

  localparam int FRAME_BITS = 40;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Byte sum wraps at 8 bits; invert is the error-injection path.
  function automatic logic [7:0] frame_cks(input logic [15:0] hum, input logic [15:0] temp,
                                           input logic invert);
    logic [7:0] sum;
    sum = hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    return invert ? ~sum : sum;
  endfunction

endpackage

// File: rtl/dht22_phase_timer.sv
// Loadable down-counter: a load of N-1 makes 'expired' rise after exactly N cycles.
module dht22_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dht22_sensor_emu.sv
// DHT22 sensor-side responder: waits for a long host low, then replies with ack and a 40-bit frame.
// The bus is open-drain: this block only ever pulls DHT_DATA low or releases it.
module dht22_sensor_emu
  import dht22_sensor_emu_pkg::*;
#(
  parameter int CYC_PER_US     = DEF_CYC_PER_US,
  parameter int T_START_MIN_US = DEF_T_START_MIN_US,
  parameter int T_WAIT_US      = DEF_T_WAIT_US,
  parameter int T_ACK_US       = DEF_T_ACK_US,
  parameter int T_BIT_LOW_US   = DEF_T_BIT_LOW_US,
  parameter int T_ZERO_US      = DEF_T_ZERO_US,
  parameter int T_ONE_US       = DEF_T_ONE_US
) (
  input  logic        clk_100MHz,
  input  logic        rst_DHT,
  inout  wire         DHT_DATA,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  input  logic        corrupt_cks,
  output logic        busy,
  output logic        frame_done
);

  localparam int START_CYC = T_START_MIN_US * CYC_PER_US;
  localparam int LW        = $clog2(START_CYC + 1);
  localparam int MAX_CYC   = CYC_PER_US * max_of(max_of(max_of(T_WAIT_US, T_ACK_US),
                                                        max_of(T_BIT_LOW_US, T_ZERO_US)), T_ONE_US);
  localparam int TW        = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] WAIT_LD    = TW'(T_WAIT_US * CYC_PER_US - 1);
  localparam logic [TW-1:0] ACK_LD     = TW'(T_ACK_US * CYC_PER_US - 1);
  localparam logic [TW-1:0] BIT_LOW_LD = TW'(T_BIT_LOW_US * CYC_PER_US - 1);
  localparam logic [TW-1:0] ZERO_LD    = TW'(T_ZERO_US * CYC_PER_US - 1);
  localparam logic [TW-1:0] ONE_LD     = TW'(T_ONE_US * CYC_PER_US - 1);

  state_t                  state, state_nxt;
  logic                    sync_meta, din_s;
  logic [LW-1:0]           low_cnt;
  logic [FRAME_BITS-1:0]   frame;
  logic [5:0]              bit_idx;
  logic                    tmr_load, tmr_expired;
  logic [TW-1:0]           tmr_val;
  logic                    drive_low;
  logic                    accept;

  dht22_phase_timer #(.W(TW)) u_timer (
    .clk      (clk_100MHz),
    .rst      (rst_DHT),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign DHT_DATA = drive_low ? 1'b0 : 1'bz;
  assign accept   = (state == ST_HOST_LOW) && din_s && (low_cnt >= LW'(START_CYC));

  always_ff @(posedge clk_100MHz) begin
    if (rst_DHT) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = BIT_LOW_LD;
    drive_low = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!din_s) state_nxt = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (accept) begin
          state_nxt = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = WAIT_LD;
        end else if (din_s) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (tmr_expired) begin
          state_nxt = ST_ACK_LOW;
          tmr_load  = 1'b1;
          tmr_val   = ACK_LD;
        end
      end
      ST_ACK_LOW: begin
        busy      = 1'b1;
        drive_low = 1'b1;
        if (tmr_expired) begin
          state_nxt = ST_ACK_HIGH;
          tmr_load  = 1'b1;
          tmr_val   = ACK_LD;
        end
      end
      ST_ACK_HIGH: begin
        busy = 1'b1;
        if (tmr_expired) begin
          state_nxt = ST_BIT_LOW;
          tmr_load  = 1'b1;
          tmr_val   = BIT_LOW_LD;
        end
      end
      ST_BIT_LOW: begin
        busy      = 1'b1;
        drive_low = 1'b1;
        if (tmr_expired) begin
          state_nxt = ST_BIT_HIGH;
          tmr_load  = 1'b1;
          tmr_val   = frame[bit_idx] ? ONE_LD : ZERO_LD;
        end
      end
      ST_BIT_HIGH: begin
        busy = 1'b1;
        if (tmr_expired) begin
          state_nxt = (bit_idx == 6'd0) ? ST_END : ST_BIT_LOW;
          tmr_load  = 1'b1;
          tmr_val   = BIT_LOW_LD;
        end
      end
      ST_END: begin
        busy      = 1'b1;
        drive_low = 1'b1;
        if (tmr_expired) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        // Our own end pulse must clear the synchronizer before a new start can be seen.
        if (din_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst_DHT) begin
      sync_meta  <= 1'b1;
      din_s      <= 1'b1;
      low_cnt    <= '0;
      frame      <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      sync_meta  <= DHT_DATA;
      din_s      <= sync_meta;
      frame_done <= (state == ST_END) && tmr_expired;
      if (state == ST_IDLE) begin
        low_cnt <= LW'(1);
      end else if (state == ST_HOST_LOW && !din_s && low_cnt != '1) begin
        low_cnt <= low_cnt + 1'b1;
      end
      if (accept) begin
        frame <= {humidity, temperature, frame_cks(humidity, temperature, corrupt_cks)};
      end
      if (state == ST_ACK_HIGH) begin
        bit_idx <= 6'(FRAME_BITS - 1);
      end else if (state == ST_BIT_HIGH && tmr_expired && bit_idx != 6'd0) begin
        bit_idx <= bit_idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Bench for dht22_sensor_emu at one cycle per microsecond with a pulled-up shared bus.
// Frames are decoded from bus run lengths and compared with a byte-sum reference model.
module tb_dht22_sensor_emu;

  localparam int T_WAIT    = 30;
  localparam int T_ACK     = 80;
  localparam int T_BIT_LOW = 50;
  localparam int T_ZERO    = 27;
  localparam int T_ONE     = 70;
  localparam int SYNC_LAT  = 3;     // two synchronizer flops plus the state register
  localparam int RUN_LIMIT = 3000;

  typedef struct {
    logic [15:0] hum;
    logic [15:0] temp;
    logic        corrupt;
    int          low_len;
    logic [39:0] exp_frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_low;
  logic [15:0] hum, temp;
  logic        corrupt;
  logic        busy, frame_done;
  wire         dht_data;

  pullup pu (dht_data);
  assign dht_data = host_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht22_sensor_emu #(.CYC_PER_US(1)) dut (
    .clk_100MHz  (clk),
    .rst_DHT     (rst),
    .DHT_DATA    (dht_data),
    .humidity    (hum),
    .temperature (temp),
    .corrupt_cks (corrupt),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [39:0] exp_q[$];

  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t,
                                              input logic c);
    int s;
    logic [7:0] k;
    s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    s = s % 256;
    if (c) s = 255 - s;
    k = 8'(s);
    return {h, t, k};
  endfunction

  function automatic int high_len(input logic b);
    return b ? T_ONE : T_ZERO;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic meas_run(input logic lvl, output int n);
    n = 0;
    while (dht_data === lvl && n < RUN_LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic host_start(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
    #1;
  endtask

  task automatic preamble(input string name);
    int n;
    meas_run(1'b1, n);
    check_int({name, "_wait"}, n, SYNC_LAT + T_WAIT);
    check_int({name, "_busy"}, int'(busy), 1);
    meas_run(1'b0, n);
    check_int({name, "_ack_low"}, n, T_ACK);
    meas_run(1'b1, n);
    check_int({name, "_ack_high"}, n, T_ACK);
  endtask

  task automatic read_bits(input int nb, inout logic [39:0] got, inout int errs);
    int n, h;
    for (int k = 0; k < nb; k++) begin
      meas_run(1'b0, n);
      if (n != T_BIT_LOW) errs++;
      meas_run(1'b1, h);
      if (h != T_ZERO && h != T_ONE) errs++;
      got = {got[38:0], (h > (T_ZERO + T_ONE) / 2)};
    end
  endtask

  task automatic finish_frame(input string name, input logic [39:0] got, input int errs,
                              input int d0);
    int n;
    logic [39:0] exp;
    exp = exp_q.pop_front();
    check_int({name, "_bit_timing"}, errs, 0);
    check_frame({name, "_frame"}, got, exp);
    meas_run(1'b0, n);
    check_int({name, "_end_low"}, n, T_BIT_LOW);
    check_int({name, "_done_pulse"}, int'(frame_done), 1);
    check_int({name, "_busy_after"}, int'(busy), 0);
    @(negedge clk);
    check_int({name, "_done_one_cycle"}, int'(frame_done), 0);
    check_int({name, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic run_frame(input string name, input int low_len, input logic [39:0] exp);
    logic [39:0] got;
    int errs, d0;
    exp_q.push_back(exp);
    d0 = done_cnt;
    got = '0;
    errs = 0;
    host_start(low_len);
    preamble(name);
    read_bits(40, got, errs);
    finish_frame(name, got, errs, d0);
  endtask

  task automatic check_idle(input string name, input int cycles);
    int lows, busys, d0;
    lows = 0;
    busys = 0;
    d0 = done_cnt;
    repeat (cycles) begin
      @(negedge clk);
      if (dht_data !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check_int({name, "_bus_low"}, lows, 0);
    check_int({name, "_busy"}, busys, 0);
    check_int({name, "_no_done"}, done_cnt - d0, 0);
  endtask

  vec_t vecs[4];

  initial begin
    logic [39:0] got, exp5;
    int errs, d0, n, busy_low, rem;

    vecs[0] = '{16'h028C, 16'h010F, 1'b0, 1000, 40'h028C010F9E};
    vecs[1] = '{16'hFFFF, 16'hFF02, 1'b0, 520,  40'hFFFFFF02FF};
    vecs[2] = '{16'hFFFF, 16'hFF02, 1'b1, 520,  40'hFFFFFF0200};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 520,  40'h00000000FF};

    rst = 1'b1;
    host_low = 1'b0;
    hum = '0;
    temp = '0;
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset_bus", int'(dht_data === 1'b1), 1);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(frame_done), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      hum = vecs[i].hum;
      temp = vecs[i].temp;
      corrupt = vecs[i].corrupt;
      run_frame($sformatf("vec%0d", i), vecs[i].low_len, vecs[i].exp_frame);
      repeat (20) @(negedge clk);
    end

    // Short host lows are glitches: no response, then a normal start is served.
    hum = 16'h1234;
    temp = 16'h8055;
    corrupt = 1'b0;
    host_start(300);
    check_idle("glitch300", 150);
    host_start(499);
    check_idle("glitch499", 150);
    run_frame("after_glitch", 1000, model_frame(hum, temp, corrupt));
    repeat (20) @(negedge clk);
    run_frame("min_start", 500, model_frame(hum, temp, corrupt));
    repeat (20) @(negedge clk);

    for (int r = 0; r < 2; r++) begin
      hum = 16'($urandom);
      temp = 16'($urandom);
      corrupt = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", r), 520, model_frame(hum, temp, corrupt));
      repeat ($urandom_range(10, 40)) @(negedge clk);
    end

    // Reset at the low preamble of bit 20 aborts the frame without a done pulse.
    hum = 16'hA5C3;
    temp = 16'h0F0F;
    corrupt = 1'b0;
    d0 = done_cnt;
    got = '0;
    errs = 0;
    host_start(520);
    preamble("reset_mid");
    read_bits(19, got, errs);
    rst = 1'b1;
    @(negedge clk);
    check_int("reset_mid_bus", int'(dht_data === 1'b1), 1);
    check_int("reset_mid_busy", int'(busy), 0);
    rst = 1'b0;
    check_idle("reset_mid_quiet", 60);
    check_int("reset_mid_no_done", done_cnt - d0, 0);
    run_frame("after_reset", 520, model_frame(hum, temp, corrupt));
    repeat (20) @(negedge clk);

    // Inputs change after the snapshot and the host pulls low during a bit high time.
    hum = 16'h3C5A;
    temp = 16'h8123;
    corrupt = 1'b0;
    exp5 = model_frame(hum, temp, corrupt);
    d0 = done_cnt;
    got = '0;
    errs = 0;
    host_start(520);
    preamble("midframe");
    hum = 16'hFFFF;
    temp = 16'h0000;
    corrupt = 1'b1;
    read_bits(34, got, errs);
    check_int("midframe_bit_timing", errs, 0);
    check_frame("midframe_upper_bits", {got[33:0], 6'b0}, {exp5[39:6], 6'b0});
    meas_run(1'b0, n);
    check_int("midframe_bit5_low", n, T_BIT_LOW);
    rem = high_len(exp5[5]) + T_BIT_LOW;
    for (int b = 4; b >= 0; b--) rem += T_BIT_LOW + high_len(exp5[b]);
    host_low = 1'b1;
    n = 0;
    busy_low = 0;
    while (frame_done !== 1'b1 && n < RUN_LIMIT) begin
      @(negedge clk);
      n++;
      if (n == 100) host_low = 1'b0;
      if (frame_done !== 1'b1 && busy !== 1'b1) busy_low++;
    end
    host_low = 1'b0;
    check_int("midframe_done_time", n, rem);
    check_int("midframe_busy_held", busy_low, 0);
    @(negedge clk);
    check_int("midframe_done_count", done_cnt - d0, 1);
    check_idle("midframe_no_restart", 200);

    // Back-to-back start ten cycles after frame_done, then the end pulse alone stays silent.
    hum = 16'h0190;
    temp = 16'hFFEC;
    corrupt = 1'b0;
    run_frame("b2b_first", 520, model_frame(hum, temp, corrupt));
    repeat (8) @(negedge clk);
    hum = 16'h7FFF;
    temp = 16'h8001;
    run_frame("b2b_second", 520, model_frame(hum, temp, corrupt));
    check_idle("end_pulse_only", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
